// File: rtl/softmax_pkg.sv
// Shared constants and FSM state type for the softmax output stream blocks.
package softmax_pkg;

  localparam int unsigned DATA_SIZE = 16;
  localparam int unsigned LANES     = 2;
  localparam int unsigned IDX_SIZE  = 8;

  typedef enum logic {
    S_RUN,
    S_RESULT
  } state_t;

endpackage

// File: rtl/softmax_skid_16.sv
// 2-entry AXI-stream skid buffer (data + last); registered s_ready_o, latency 1.
module softmax_skid_16
  import softmax_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s_valid_i,
  input  logic                       s_last_i,
  input  logic [LANES*data_size-1:0] s_data_i,
  output logic                       s_ready_o,
  input  logic                       m_ready_i,
  output logic                       m_valid_o,
  output logic                       m_last_o,
  output logic [LANES*data_size-1:0] m_data_o
);

  localparam int unsigned W = LANES * data_size;

  logic [W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic         head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]   count_q, count_d;
  logic         s_ready_q, s_ready_d;
  logic         push, pop;

  assign push = s_valid_i & s_ready_q;
  assign pop  = (count_q != 2'd0) & m_ready_i;

  // Next occupancy and entry contents; head is always the oldest beat.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = s_data_i;
          head_last_d = s_last_i;
        end else begin
          tail_data_d = s_data_i;
          tail_last_d = s_last_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = s_data_i;
          head_last_d = s_last_i;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = s_data_i;
          tail_last_d = s_last_i;
        end
      end
      default: ;
    endcase
    s_ready_d = (count_d != 2'd2);
  end

  // Entry and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= '0;
      s_ready_q   <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_last_o  = head_last_q;
  assign m_data_o  = head_data_q;

endmodule

// File: rtl/softmax_argmax_16.sv
// Passthrough of the softmax probability stream with per-vector argmax result.
// Optional SOFTMAX_ARGMAX_SUM_EN adds res_sum_o, the sum of all lanes of the vector.
module softmax_argmax_16
  import softmax_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned idx_size  = IDX_SIZE
) (
  input  logic                       axi_clock_i,
  input  logic                       axi_reset_i,
  input  logic                       s_axis_valid_i,
  input  logic                       s_axis_last_i,
  input  logic [LANES*data_size-1:0] s_axis_data_i,
  output logic                       s_axis_ready_o,
  input  logic                       m_axis_ready_i,
  output logic                       m_axis_valid_o,
  output logic                       m_axis_last_o,
  output logic [LANES*data_size-1:0] m_axis_data_o,
  input  logic                       res_ready_i,
  output logic                       res_valid_o,
  output logic [idx_size-1:0]        res_index_o,
  output logic [data_size-1:0]       res_value_o,
  output logic                       overflow_o
`ifdef SOFTMAX_ARGMAX_SUM_EN
  ,
  output logic [data_size+idx_size-1:0] res_sum_o
`endif
);

  localparam logic [idx_size:0] CNT_STEP = (idx_size + 1)'(LANES);

  state_t                state_q, state_d;
  logic [data_size-1:0]  max_q, max_d, res_value_q, res_value_d, beat_max;
  logic [idx_size-1:0]   idx_q, idx_d, res_index_q, res_index_d, beat_idx;
  logic [idx_size:0]     cnt_q, cnt_d, cnt_next;
  logic                  res_valid_q, res_valid_d, overflow_q, overflow_d;
  logic                  skid_ready, last_ok, accept, in_range;
  logic [data_size-1:0]  lane0, lane1;

  assign lane0    = s_axis_data_i[data_size-1:0];
  assign lane1    = s_axis_data_i[2*data_size-1:data_size];
  // A last beat may enter only once the previous result is gone or leaves this cycle.
  assign last_ok  = (state_q == S_RUN) | res_ready_i;
  assign s_axis_ready_o = skid_ready & (~s_axis_last_i | last_ok);
  assign accept   = s_axis_valid_i & s_axis_ready_o;
  // Count is always even, so its MSB alone says both lanes are past the index limit.
  assign in_range = ~cnt_q[idx_size];

  softmax_skid_16 #(.data_size(data_size)) u_skid (
    .clk_i     (axi_clock_i),
    .rst_i     (axi_reset_i),
    .s_valid_i (s_axis_valid_i & (~s_axis_last_i | last_ok)),
    .s_last_i  (s_axis_last_i),
    .s_data_i  (s_axis_data_i),
    .s_ready_o (skid_ready),
    .m_ready_i (m_axis_ready_i),
    .m_valid_o (m_axis_valid_o),
    .m_last_o  (m_axis_last_o),
    .m_data_o  (m_axis_data_o)
  );

  // Running max folded with this beat's lanes in order lane0, lane1; strict > keeps lowest index.
  always_comb begin
    beat_max = max_q;
    beat_idx = idx_q;
    if (cnt_q == '0) begin
      beat_max = lane0;
      beat_idx = '0;
    end else if (in_range && (lane0 > beat_max)) begin
      beat_max = lane0;
      beat_idx = cnt_q[idx_size-1:0];
    end
    if (in_range && (lane1 > beat_max)) begin
      beat_max = lane1;
      beat_idx = {cnt_q[idx_size-1:1], 1'b1};
    end
    cnt_next = in_range ? cnt_q + CNT_STEP : cnt_q;
  end

  // Result FSM and tracker update; a last accept overrides the handshake exit to S_RUN.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_index_d = res_index_q;
    res_value_d = res_value_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      S_RUN: ;
      S_RESULT: begin
        if (res_ready_i) begin
          state_d     = S_RUN;
          res_valid_d = 1'b0;
        end
      end
    endcase
    if (accept) begin
      if (!in_range) overflow_d = 1'b1;
      if (s_axis_last_i) begin
        state_d     = S_RESULT;
        res_valid_d = 1'b1;
        res_index_d = beat_idx;
        res_value_d = beat_max;
        max_d       = '0;
        idx_d       = '0;
        cnt_d       = '0;
      end else begin
        max_d = beat_max;
        idx_d = beat_idx;
        cnt_d = cnt_next;
      end
    end
  end

  // State, tracker and result registers.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      state_q     <= S_RUN;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_value_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_value_q <= res_value_d;
      overflow_q  <= overflow_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_index_o = res_index_q;
  assign res_value_o = res_value_q;
  assign overflow_o  = overflow_q;

`ifdef SOFTMAX_ARGMAX_SUM_EN
  localparam int unsigned SUM_W = data_size + idx_size;

  logic [SUM_W-1:0] sum_q, sum_d, res_sum_q, res_sum_d, beat_sum;

  // Lane accumulator, latched into the result on the last beat and then cleared.
  always_comb begin
    beat_sum  = sum_q + SUM_W'(lane0) + SUM_W'(lane1);
    sum_d     = sum_q;
    res_sum_d = res_sum_q;
    if (accept) begin
      if (s_axis_last_i) begin
        res_sum_d = beat_sum;
        sum_d     = '0;
      end else begin
        sum_d = beat_sum;
      end
    end
  end

  // Accumulator and result sum registers.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      sum_q     <= '0;
      res_sum_q <= '0;
    end else begin
      sum_q     <= sum_d;
      res_sum_q <= res_sum_d;
    end
  end

  assign res_sum_o = res_sum_q;
`endif

endmodule
